// File: rtl/unit_dispatcher_pkg.sv
// -----------------------------------------------------------------------------
// unit_dispatcher_pkg
// Shared definitions for the NPU unit dispatcher:
//   - 2-bit FSM state encoding (IDLE, ISSUE, WAIT_DONE, RESPOND)
//   - unit command record {ptr, params, tag} as carried through the FIFO
//   - default FIFO depth and default WAIT_DONE timeout
//   - saturating 8-bit increment used by the error counter
// -----------------------------------------------------------------------------
package unit_dispatcher_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ISSUE   = 2'd1;
   localparam logic [1:0] ST_WAIT    = 2'd2;
   localparam logic [1:0] ST_RESPOND = 2'd3;

   localparam int DEFAULT_CMD_DEPTH = 4;
   localparam int DEFAULT_TIMEOUT   = 1024;

   typedef struct packed {
      logic [31:0] ptr;
      logic [31:0] params;
      logic [3:0]  tag;
   } unit_cmd_t;

   localparam int UNIT_CMD_W = $bits(unit_cmd_t);

   // Increment that sticks at 8'hFF instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/unit_dispatcher_cmd_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo
// Synchronous FIFO with registered full/empty flags and single-cycle push/pop.
// The head entry is presented combinationally on rdata while empty is low.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (empties the FIFO)
//   push, wdata     write request and data (ignored while full)
//   pop,  rdata     read request (ignored while empty) and head data
//   full, empty     registered occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module cmd_fifo #(
   parameter int WIDTH = 68,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic [AW:0]      count_next_s;
   logic             full_r;
   logic             empty_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   // Qualify requests against the registered flags and compute next occupancy.
   always_comb begin
      push_ok_s    = push && !full_r;
      pop_ok_s     = pop && !empty_r;
      count_next_s = count_r;
      if (push_ok_s && !pop_ok_s) begin
         count_next_s = count_r + (AW+1)'(1);
      end else if (!push_ok_s && pop_ok_s) begin
         count_next_s = count_r - (AW+1)'(1);
      end else begin
         count_next_s = count_r;
      end
   end

   // Pointer, occupancy and flag registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r <= count_next_s;
         full_r  <= (count_next_s == (AW+1)'(DEPTH));
         empty_r <= (count_next_s == (AW+1)'(0));
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   assign rdata = mem_r[rd_ptr_r];
   assign full  = full_r;
   assign empty = empty_r;

endmodule

// File: rtl/unit_dispatcher.sv
// -----------------------------------------------------------------------------
// unit_dispatcher
// Queues commands in a FIFO and dispatches them one at a time to a compute
// unit, waiting for completion (or a timeout abort) before responding.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   cmd_valid/cmd_ready              command handshake (ready = FIFO not full)
//   cmd_ptr, cmd_params, cmd_tag     command payload
//   unit_start                       one-cycle start pulse to the unit
//   unit_input_ptr, unit_params      operands held stable for the whole command
//   unit_ready, unit_done            unit idle / completion pulse
//   unit_result                      unit result, valid with unit_done
//   rsp_valid/rsp_ready              response handshake
//   rsp_data, rsp_tag, rsp_timeout   response payload (data 0 on timeout)
//   busy                             FSM active or commands queued
//   err_count                        saturating timeout counter
// -----------------------------------------------------------------------------
module unit_dispatcher
   import unit_dispatcher_pkg::*;
#(
   parameter int CMD_DEPTH = DEFAULT_CMD_DEPTH,
   parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_ptr,
   input  logic [31:0] cmd_params,
   input  logic [3:0]  cmd_tag,
   output logic        unit_start,
   output logic [31:0] unit_input_ptr,
   output logic [31:0] unit_params,
   input  logic        unit_ready,
   input  logic        unit_done,
   input  logic [31:0] unit_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [3:0]  rsp_tag,
   output logic        rsp_timeout,
   output logic        busy,
   output logic [7:0]  err_count
);

   localparam int TW = $clog2(TIMEOUT);

   logic [1:0]    state_r;
   unit_cmd_t     hold_r;
   logic [TW-1:0] to_cnt_r;
   logic [31:0]   rsp_data_r;
   logic [3:0]    rsp_tag_r;
   logic          rsp_to_r;
   logic [7:0]    err_cnt_r;

   unit_cmd_t     fifo_wdata_s;
   unit_cmd_t     fifo_rdata_s;
   logic          fifo_full_s;
   logic          fifo_empty_s;
   logic          fifo_push_s;
   logic          fifo_pop_s;
   logic          timeout_hit_s;

   // Push/pop requests and timeout detection.
   always_comb begin
      fifo_wdata_s.ptr    = cmd_ptr;
      fifo_wdata_s.params = cmd_params;
      fifo_wdata_s.tag    = cmd_tag;
      fifo_push_s         = cmd_valid && !fifo_full_s;
      fifo_pop_s          = (state_r == ST_IDLE) && !fifo_empty_s;
      timeout_hit_s       = (to_cnt_r == TW'(TIMEOUT - 1));
   end

   cmd_fifo #(
      .WIDTH (UNIT_CMD_W),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push_s),
      .wdata (fifo_wdata_s),
      .pop   (fifo_pop_s),
      .rdata (fifo_rdata_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // Dispatcher FSM with holding, timeout, response and error registers.
   // The holding register drives the unit operands directly, so they stay
   // stable from ISSUE entry until the next pop after RESPOND.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         hold_r     <= '0;
         to_cnt_r   <= '0;
         rsp_data_r <= 32'h0000_0000;
         rsp_tag_r  <= 4'h0;
         rsp_to_r   <= 1'b0;
         err_cnt_r  <= 8'h00;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (!fifo_empty_s) begin
                  hold_r  <= fifo_rdata_s;
                  state_r <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // No timeout here: a busy unit may stall issue indefinitely.
               if (unit_ready) begin
                  to_cnt_r <= '0;
                  state_r  <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               to_cnt_r <= to_cnt_r + TW'(1);
               // Completion takes priority over a coinciding timeout.
               if (unit_done) begin
                  rsp_data_r <= unit_result;
                  rsp_tag_r  <= hold_r.tag;
                  rsp_to_r   <= 1'b0;
                  state_r    <= ST_RESPOND;
               end else if (timeout_hit_s) begin
                  rsp_data_r <= 32'h0000_0000;
                  rsp_tag_r  <= hold_r.tag;
                  rsp_to_r   <= 1'b1;
                  err_cnt_r  <= sat_inc8(err_cnt_r);
                  state_r    <= ST_RESPOND;
               end
            end
            ST_RESPOND: begin
               if (rsp_ready) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Outputs are decoded from registered state only, except unit_start which
   // must coincide with the cycle the unit reports ready.
   always_comb begin
      cmd_ready      = !fifo_full_s;
      unit_start     = (state_r == ST_ISSUE) && unit_ready;
      unit_input_ptr = hold_r.ptr;
      unit_params    = hold_r.params;
      rsp_valid      = (state_r == ST_RESPOND);
      rsp_data       = rsp_data_r;
      rsp_tag        = rsp_tag_r;
      rsp_timeout    = rsp_to_r;
      busy           = (state_r != ST_IDLE) || !fifo_empty_s;
      err_count      = err_cnt_r;
   end

endmodule

// File: tb/tb_unit_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_unit_dispatcher
// Directed self-checking bench for unit_dispatcher (CMD_DEPTH=4, TIMEOUT=16).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_unit_dispatcher;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_ptr;
   logic [31:0] cmd_params;
   logic [3:0]  cmd_tag;
   logic        unit_start;
   logic [31:0] unit_input_ptr;
   logic [31:0] unit_params;
   logic        unit_ready;
   logic        unit_done;
   logic [31:0] unit_result;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [3:0]  rsp_tag;
   logic        rsp_timeout;
   logic        busy;
   logic [7:0]  err_count;

   int n_cmp = 0;
   int n_bad = 0;
   int n_starts = 0;
   logic [3:0]  q_tag [$];
   logic        q_to  [$];
   logic [31:0] q_data[$];

   always #5 clk = ~clk;

   unit_dispatcher #(.CMD_DEPTH(4), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ptr(cmd_ptr), .cmd_params(cmd_params), .cmd_tag(cmd_tag),
      .unit_start(unit_start), .unit_input_ptr(unit_input_ptr), .unit_params(unit_params),
      .unit_ready(unit_ready), .unit_done(unit_done), .unit_result(unit_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout),
      .busy(busy), .err_count(err_count)
   );

   // Count start pulses and record every accepted response.
   always @(posedge clk) begin
      if (unit_start) n_starts++;
      if (rst_n && rsp_valid && rsp_ready) begin
         q_tag.push_back(rsp_tag);
         q_to.push_back(rsp_timeout);
         q_data.push_back(rsp_data);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_cmd(input logic [31:0] p, input logic [31:0] prm, input logic [3:0] t);
      cmd_valid = 1'b1; cmd_ptr = p; cmd_params = prm; cmd_tag = t;
      cyc();
      cmd_valid = 1'b0;
   endtask

   // Bounded wait until unit_start is visible; expiry is a failed comparison.
   task automatic wait_start(input string tag);
      int k;
      k = 0;
      #1;
      while (!unit_start && k < 64) begin
         cyc();
         k++;
      end
      chk(tag, unit_start, 32'd1);
   endtask

   // Wait for a start, complete it lat cycles later with result res.
   task automatic serve(input int lat, input logic [31:0] res);
      logic early;
      early = 1'b0;
      wait_start("serve_start");
      for (int i = 0; i < lat; i++) begin
         cyc();
         if (rsp_valid) early = 1'b1;
      end
      chk("serve_no_early_rsp", early, 32'd0);
      unit_done = 1'b1; unit_result = res;
      cyc();
      unit_done = 1'b0;
      chk("serve_rsp_valid", rsp_valid, 32'd1);
   endtask

   initial begin
      logic        early;
      logic        moved;
      int          s0;
      int          qn;
      int          k;
      logic [31:0] d0;
      logic [3:0]  t0;
      logic        o0;

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_ptr = 32'h0; cmd_params = 32'h0; cmd_tag = 4'h0;
      unit_ready = 1'b0; unit_done = 1'b0; unit_result = 32'h0; rsp_ready = 1'b0;
      cyc(); cyc(); cyc();

      // Reset values.
      chk("rst_cmd_ready", cmd_ready, 32'd1);
      chk("rst_unit_start", unit_start, 32'd0);
      chk("rst_rsp_valid", rsp_valid, 32'd0);
      chk("rst_busy", busy, 32'd0);
      chk("rst_err_count", err_count, 32'd0);
      chk("rst_unit_ptr", unit_input_ptr, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      rst_n = 1'b1;
      cyc();

      // Single command, unit done 10 cycles after start.
      unit_ready = 1'b1; rsp_ready = 1'b0;
      s0 = n_starts;
      push_cmd(32'h0000_1000, 32'h0002_0001, 4'd3);
      chk("t1_busy", busy, 32'd1);
      wait_start("t1_start");
      chk("t1_unit_ptr", unit_input_ptr, 32'h0000_1000);
      chk("t1_unit_params", unit_params, 32'h0002_0001);
      early = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (rsp_valid) early = 1'b1;
      end
      chk("t1_no_early_rsp", early, 32'd0);
      unit_done = 1'b1; unit_result = 32'h0000_0001;
      cyc();
      unit_done = 1'b0; unit_result = 32'h0;
      chk("t1_rsp_valid", rsp_valid, 32'd1);
      chk("t1_rsp_data", rsp_data, 32'h0000_0001);
      chk("t1_rsp_tag", rsp_tag, 32'd3);
      chk("t1_rsp_timeout", rsp_timeout, 32'd0);
      chk("t1_ptr_stable", unit_input_ptr, 32'h0000_1000);
      cyc(); cyc();
      chk("t1_one_start", n_starts - s0, 32'd1);
      rsp_ready = 1'b1;
      cyc();
      chk("t1_rsp_drop", rsp_valid, 32'd0);
      chk("t1_idle", busy, 32'd0);

      // FIFO full with the unit stalled: tag 1 sits in ISSUE, tags 2..5 fill
      // the FIFO, tag 6 is offered and must wait for a pop.
      q_tag.delete(); q_to.delete(); q_data.delete();
      unit_ready = 1'b0;
      s0 = n_starts;
      cmd_valid = 1'b1;
      for (int t = 1; t <= 5; t++) begin
         cmd_ptr = 32'h100 * t; cmd_params = 32'h0; cmd_tag = 4'(t);
         if (t == 5) chk("t2_ready_before_4th", cmd_ready, 32'd1);
         cyc();
      end
      chk("t2_ready_dropped", cmd_ready, 32'd0);
      cmd_tag = 4'd6; cmd_ptr = 32'h600;
      moved = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         if (cmd_ready || unit_start) moved = 1'b1;
      end
      chk("t2_held_full_no_start", moved, 32'd0);
      chk("t2_stall_starts", n_starts - s0, 32'd0);
      unit_ready = 1'b1;
      serve(1, 32'hA1);
      unit_ready = 1'b0;
      k = 0;
      while (!cmd_ready && k < 20) begin
         cyc();
         k++;
      end
      chk("t2_ready_after_pop", cmd_ready, 32'd1);
      cyc();
      cmd_valid = 1'b0;
      unit_ready = 1'b1;
      for (int i = 0; i < 5; i++) serve(2, 32'hB0 + i);
      cyc(); cyc();
      chk("t2_rsp_count", q_tag.size(), 32'd6);
      for (int i = 0; i < 6; i++) chk("t2_rsp_order", q_tag[i], 32'(i + 1));
      chk("t2_err_count", err_count, 32'd0);

      // Timeout after 16 WAIT_DONE cycles, then a stray done in IDLE.
      rsp_ready = 1'b0;
      push_cmd(32'h700, 32'h7, 4'd7);
      wait_start("t3_start");
      early = 1'b0;
      for (int i = 0; i < 16; i++) begin
         cyc();
         if (rsp_valid) early = 1'b1;
      end
      chk("t3_no_early_rsp", early, 32'd0);
      cyc();
      chk("t3_rsp_valid", rsp_valid, 32'd1);
      chk("t3_rsp_timeout", rsp_timeout, 32'd1);
      chk("t3_rsp_data", rsp_data, 32'd0);
      chk("t3_rsp_tag", rsp_tag, 32'd7);
      chk("t3_err_count", err_count, 32'd1);
      rsp_ready = 1'b1;
      cyc();
      qn = q_tag.size(); s0 = n_starts;
      unit_done = 1'b1; unit_result = 32'hDEAD;
      cyc();
      unit_done = 1'b0;
      cyc(); cyc();
      chk("t3_stray_rsp", rsp_valid, 32'd0);
      chk("t3_stray_err", err_count, 32'd1);
      chk("t3_stray_busy", busy, 32'd0);
      chk("t3_stray_queue", q_tag.size() - qn, 32'd0);

      // done on the final timeout cycle wins.
      rsp_ready = 1'b0;
      push_cmd(32'h800, 32'h8, 4'd8);
      wait_start("t4_start");
      for (int i = 0; i < 16; i++) cyc();
      chk("t4_still_waiting", rsp_valid, 32'd0);
      unit_done = 1'b1; unit_result = 32'h00C0_FFEE;
      cyc();
      unit_done = 1'b0;
      chk("t4_rsp_valid", rsp_valid, 32'd1);
      chk("t4_rsp_timeout", rsp_timeout, 32'd0);
      chk("t4_rsp_data", rsp_data, 32'h00C0_FFEE);
      chk("t4_err_count", err_count, 32'd1);
      rsp_ready = 1'b1;
      cyc();

      // Response backpressure for 20 cycles with another command queued.
      rsp_ready = 1'b0;
      push_cmd(32'h900, 32'h9, 4'd9);
      push_cmd(32'hA00, 32'hA, 4'd10);
      serve(3, 32'h99);
      d0 = rsp_data; t0 = rsp_tag; o0 = rsp_timeout; s0 = n_starts;
      chk("t5_rsp_data", d0, 32'h99);
      chk("t5_rsp_tag", t0, 32'd9);
      moved = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (!rsp_valid || rsp_data !== d0 || rsp_tag !== t0 || rsp_timeout !== o0 || unit_start)
            moved = 1'b1;
      end
      chk("t5_stable", moved, 32'd0);
      chk("t5_no_start", n_starts - s0, 32'd0);
      rsp_ready = 1'b1;
      serve(2, 32'h1010);
      chk("t5_second_tag", rsp_tag, 32'd10);
      chk("t5_second_data", rsp_data, 32'h1010);
      cyc();

      // Reset in WAIT_DONE with another command queued.
      qn = q_tag.size();
      push_cmd(32'hB00, 32'hB, 4'd11);
      push_cmd(32'hC00, 32'hC, 4'd12);
      wait_start("t6_start");
      cyc(); cyc(); cyc();
      rst_n = 1'b0;
      cyc();
      chk("t6_cmd_ready", cmd_ready, 32'd1);
      chk("t6_unit_start", unit_start, 32'd0);
      chk("t6_rsp_valid", rsp_valid, 32'd0);
      chk("t6_busy", busy, 32'd0);
      chk("t6_err_count", err_count, 32'd0);
      chk("t6_unit_ptr", unit_input_ptr, 32'd0);
      chk("t6_unit_params", unit_params, 32'd0);
      chk("t6_rsp_tag", rsp_tag, 32'd0);
      chk("t6_rsp_data", rsp_data, 32'd0);
      chk("t6_rsp_timeout", rsp_timeout, 32'd0);
      rst_n = 1'b1;
      s0 = n_starts;
      unit_done = 1'b1; unit_result = 32'hBAD;
      cyc();
      unit_done = 1'b0;
      for (int i = 0; i < 30; i++) cyc();
      chk("t6_no_rsp", q_tag.size() - qn, 32'd0);
      chk("t6_no_start", n_starts - s0, 32'd0);
      chk("t6_fifo_empty", busy, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
